// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and helpers for the data-memory store buffer.
// Defines the buffer entry layout, the word-index width and the
// address-to-word-index mapping used by every file of the block.
package dmem_pkg;

    localparam int DM_N         = 64;
    localparam int DM_MEM_WORDS = 64;
    localparam int DM_SB_DEPTH  = 4;

    // Width of a word index into the backing array.
    localparam int IDXW = $clog2(DM_MEM_WORDS);

    // One posted store: valid flag, target word and the data to commit.
    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] idx;
        logic [DM_N-1:0] data;
    } sb_entry_t;

    // Byte address to word index: the low three bits select a byte inside
    // a 64-bit word and are ignored, and bits above the array size alias.
    function automatic logic [IDXW-1:0] word_idx(input logic [DM_N-1:0] addr);
        return addr[IDXW+2:3];
    endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// MEM-stage to data-memory bus: request and write data flow toward the
// memory, load data and buffer status flow back to the pipeline.
interface dmem_store_buffer_if #(
    parameter int N        = dmem_pkg::DM_N,
    parameter int SB_DEPTH = dmem_pkg::DM_SB_DEPTH
);
    logic                      memWrite;
    logic                      memRead;
    logic                      flush;
    logic [N-1:0]              addr;
    logic [N-1:0]              writeData;
    logic [N-1:0]              readData;
    logic                      sb_full;
    logic                      sb_empty;
    logic [$clog2(SB_DEPTH):0] sb_count;

    modport master (
        output memWrite, memRead, flush, addr, writeData,
        input  readData, sb_full, sb_empty, sb_count
    );

    modport slave (
        input  memWrite, memRead, flush, addr, writeData,
        output readData, sb_full, sb_empty, sb_count
    );
endinterface

// File: rtl/dmem_store_buffer_sb_fwd_match.sv
// Youngest-match search over the store-buffer entries.
// Walks the ring from the head (oldest) toward the tail; a later match
// overrides an earlier one, so the result is the youngest buffered store
// to the requested word. Drained slots have valid cleared, so only live
// entries can match.
module sb_fwd_match
    import dmem_pkg::*;
#(
    parameter int SB_DEPTH = DM_SB_DEPTH
) (
    input  sb_entry_t                     i_entries [SB_DEPTH],
    input  logic [$clog2(SB_DEPTH)-1:0]   i_head,
    input  logic [IDXW-1:0]               i_idx,
    output logic                          o_hit,
    output logic [DM_N-1:0]               o_data
);
    localparam int PTRW = $clog2(SB_DEPTH);

    logic [SB_DEPTH-1:0] w_match;
    logic [PTRW-1:0]     w_slot;

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
            assign w_match[gi] = i_entries[gi].valid && (i_entries[gi].idx == i_idx);
        end
    endgenerate

    // Oldest-to-youngest scan: the last hit seen is the youngest store.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_slot = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_slot = i_head + PTRW'(k);
            if (w_match[w_slot]) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_slot].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data memory with a posted-store FIFO in front of a single-ported array.
// Stores enter the buffer and drain to the array when the port is idle,
// on flush, or when a store arrives while the buffer is full (the oldest
// entry drains on that same edge, so the buffer never overflows).
// Loads are combinational and forward from the youngest matching entry.
// Optional build macro: DMEM_SB_STATS_EN adds fwd_hits, forced_drains and
// stores_total saturating 32-bit counters.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int N         = DM_N,
    parameter int MEM_WORDS = DM_MEM_WORDS,
    parameter int SB_DEPTH  = DM_SB_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_store_buffer_if.slave   bus
`ifdef DMEM_SB_STATS_EN
    ,
    output logic [31:0]          fwd_hits,
    output logic [31:0]          forced_drains,
    output logic [31:0]          stores_total
`endif
);
    localparam int PTRW = $clog2(SB_DEPTH);
    localparam int CNTW = PTRW + 1;

    // Entry widths come from the package; N and MEM_WORDS track it.
    sb_entry_t       r_entries [SB_DEPTH];
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [CNTW-1:0] r_count;
    logic [N-1:0]    r_mem [MEM_WORDS];

    logic [IDXW-1:0] w_idx;
    logic            w_full;
    logic            w_empty;
    logic            w_idle;
    logic            w_forced;
    logic            w_drain;
    logic            w_accept;
    logic            w_hit;
    logic [N-1:0]    w_fwd_data;

    assign w_idx    = word_idx(bus.addr);
    assign w_full   = (r_count == CNTW'(SB_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_idle   = !bus.memRead && !bus.memWrite;
    assign w_forced = w_full && bus.memWrite;
    assign w_drain  = !w_empty && (w_idle || bus.flush || w_forced);
    assign w_accept = bus.memWrite;

    // Status flags come straight from registered occupancy.
    assign bus.sb_full  = w_full;
    assign bus.sb_empty = w_empty;
    assign bus.sb_count = r_count;

    sb_fwd_match #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fwd (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_idx     (w_idx),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    // Per-slot entry update; an accept into the slot being drained (the
    // full+store case, where head==tail) overwrites it, so accept wins.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_entries[gi] <= '0;
                end else if (w_accept && (r_tail == PTRW'(gi))) begin
                    r_entries[gi] <= '{valid: 1'b1, idx: w_idx, data: bus.writeData};
                end else if (w_drain && (r_head == PTRW'(gi))) begin
                    r_entries[gi].valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Ring pointers and occupancy; accept and drain together leave count as is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain)  r_head <= r_head + 1'b1;
            if (w_accept) r_tail <= r_tail + 1'b1;
            if (w_accept && !w_drain)      r_count <= r_count + 1'b1;
            else if (w_drain && !w_accept) r_count <= r_count - 1'b1;
        end
    end

    // Backing array: written only by a drain, never reset.
    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_mem[r_entries[r_head].idx] <= r_entries[r_head].data;
        end
    end

    // Zero-latency load: buffered data first, else the array, else 0.
    always_comb begin
        bus.readData = '0;
        if (bus.memRead) begin
            bus.readData = w_hit ? w_fwd_data : r_mem[w_idx];
        end
    end

`ifdef DMEM_SB_STATS_EN
    logic [31:0] r_fwd_hits;
    logic [31:0] r_forced_drains;
    logic [31:0] r_stores_total;

    // Event counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd_hits      <= '0;
            r_forced_drains <= '0;
            r_stores_total  <= '0;
        end else begin
            if (bus.memRead && w_hit && (r_fwd_hits != '1))
                r_fwd_hits <= r_fwd_hits + 1'b1;
            if (w_drain && w_forced && (r_forced_drains != '1))
                r_forced_drains <= r_forced_drains + 1'b1;
            if (w_accept && (r_stores_total != '1))
                r_stores_total <= r_stores_total + 1'b1;
        end
    end

    assign fwd_hits      = r_fwd_hits;
    assign forced_drains = r_forced_drains;
    assign stores_total  = r_stores_total;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: a queue-based reference model predicts each
// cycle's load data and occupancy, a scoreboard queue carries the
// prediction to the sample point, and a table of hand-derived vectors plus
// a few hand sequences cover forwarding, forced drain, drain order,
// same-cycle read/write and asynchronous reset. Honours DMEM_SB_STATS_EN.
module tb_dmem_store_buffer;
    import dmem_pkg::*;

    localparam int DEPTH = DM_SB_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_store_buffer_if bus ();

`ifdef DMEM_SB_STATS_EN
    logic [31:0] fwd_hits, forced_drains, stores_total;
`endif

    dmem_store_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_SB_STATS_EN
        ,
        .fwd_hits      (fwd_hits),
        .forced_drains (forced_drains),
        .stores_total  (stores_total)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [5:0] idx; logic [63:0] data; } st_t;
    typedef struct { logic [63:0] rd; logic [2:0] cnt; } exp_t;
    typedef struct {
        bit w, r, f;
        logic [63:0] a, d, exp_rd;
        logic [2:0]  exp_cnt;
    } vec_t;

    st_t         mq[$];
    exp_t        sb_q[$];
    logic [63:0] mem_m [64];
    int          m_fwd = 0, m_forced = 0, m_stores = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic bit model_hit(input logic [63:0] a);
        foreach (mq[i]) if (mq[i].idx == a[8:3]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_rd(input bit r, input logic [63:0] a);
        if (!r) return 64'h0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].idx == a[8:3]) return mq[i].data;
        return mem_m[a[8:3]];
    endfunction

    // One bus cycle: drive at negedge, sample 2ns later, commit the model,
    // then return just after the active edge with the bus idle.
    task automatic step(input bit w, input bit r, input bit f,
                        input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd_o, output logic [2:0] cnt_o);
        exp_t e;
        st_t  s;
        bit   drain;
        @(negedge clk);
        bus.memWrite = w; bus.memRead = r; bus.flush = f;
        bus.addr = a; bus.writeData = d;
        e.rd  = model_rd(r, a);
        e.cnt = 3'(mq.size());
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        rd_o  = bus.readData;
        cnt_o = bus.sb_count;
        chk("readData", bus.readData, e.rd);
        chk("sb_count", 64'(bus.sb_count), 64'(e.cnt));
        chk("sb_full",  64'(bus.sb_full),  64'(mq.size() == DEPTH));
        chk("sb_empty", 64'(bus.sb_empty), 64'(mq.size() == 0));
        if (r && model_hit(a)) m_fwd++;
        drain = (mq.size() > 0) && ((!r && !w) || f || (mq.size() == DEPTH && w));
        if (drain && mq.size() == DEPTH && w) m_forced++;
        if (drain) begin
            s = mq.pop_front();
            mem_m[s.idx] = s.data;
        end
        if (w) begin
            s.idx = a[8:3]; s.data = d;
            mq.push_back(s);
            m_stores++;
        end
        @(posedge clk);
        #1;
        bus.memWrite = 1'b0; bus.memRead = 1'b0; bus.flush = 1'b0;
    endtask

    vec_t        tbl [13];
    logic [63:0] rd;
    logic [2:0]  cnt;

    initial begin
        // Hand-derived vectors; array word k holds 0x1000+k before row 0.
        tbl[0]  = '{1, 0, 1, 64'h10, 64'hAA,   64'h0,    3'd0};
        tbl[1]  = '{0, 0, 1, 64'h0,  64'h0,    64'h0,    3'd1};
        tbl[2]  = '{0, 1, 0, 64'h10, 64'h0,    64'hAA,   3'd0};
        tbl[3]  = '{1, 0, 0, 64'h08, 64'h1111, 64'h0,    3'd0};
        tbl[4]  = '{1, 0, 0, 64'h08, 64'h2222, 64'h0,    3'd1};
        tbl[5]  = '{0, 1, 0, 64'h08, 64'h0,    64'h2222, 3'd2};
        tbl[6]  = '{0, 0, 0, 64'h0,  64'h0,    64'h0,    3'd2};
        tbl[7]  = '{0, 0, 0, 64'h0,  64'h0,    64'h0,    3'd1};
        tbl[8]  = '{0, 1, 0, 64'h08, 64'h0,    64'h2222, 3'd0};
        tbl[9]  = '{1, 1, 0, 64'h10, 64'h9,    64'hAA,   3'd0};
        tbl[10] = '{0, 1, 0, 64'h10, 64'h0,    64'h9,    3'd1};
        tbl[11] = '{0, 0, 0, 64'h0,  64'h0,    64'h0,    3'd1};
        tbl[12] = '{0, 1, 0, 64'h10, 64'h0,    64'h9,    3'd0};

        bus.memWrite = 1'b0; bus.memRead = 1'b0; bus.flush = 1'b0;
        bus.addr = '0; bus.writeData = '0;
        reset = 1'b1;
        #12;
        chk("rst_count", 64'(bus.sb_count), 64'd0);
        chk("rst_empty", 64'(bus.sb_empty), 64'd1);
        chk("rst_full",  64'(bus.sb_full),  64'd0);
        chk("rst_rdata", bus.readData, 64'h0);
        reset = 1'b0;

        // Fill the whole array through store+flush so every word is known.
        for (int k = 0; k < 64; k++) step(1, 0, 1, 64'(k) << 3, 64'h1000 + 64'(k), rd, cnt);
        step(0, 0, 1, 64'h0, 64'h0, rd, cnt);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].a, tbl[i].d, rd, cnt);
            chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].exp_cnt));
            if (i == 5) chk("fwd_array_old", dut.r_mem[1], 64'h1001);
        end

        // Fill the buffer, then a fifth store forces the oldest out.
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 64'(k) * 8, 64'hA0 + 64'(k), rd, cnt);
            chk("fill_cnt", 64'(cnt), 64'(k));
        end
        chk("full_before", 64'(bus.sb_full), 64'd1);
        step(1, 0, 0, 64'h20, 64'hA4, rd, cnt);
        chk("forced_full",  64'(bus.sb_full), 64'd1);
        chk("forced_count", 64'(bus.sb_count), 64'd4);
        chk("forced_mem0",  dut.r_mem[0], 64'hA0);
        chk("forced_mem1",  dut.r_mem[1], 64'h2222);

        // Idle cycles drain in FIFO order.
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 64'h0, 64'h0, rd, cnt);
            chk("drain_cnt", 64'(cnt), 64'(4 - k));
            chk($sformatf("drain_mem%0d", k + 1), dut.r_mem[k + 1], 64'hA1 + 64'(k));
        end
        chk("drain_empty", 64'(bus.sb_empty), 64'd1);

        // Asynchronous reset with two stores pending discards them.
        step(1, 0, 0, 64'h28, 64'hB0, rd, cnt);
        step(1, 0, 0, 64'h30, 64'hB1, rd, cnt);
        chk("pre_rst_cnt", 64'(bus.sb_count), 64'd2);
        reset = 1'b1;
        #1;
        chk("async_rst_cnt",   64'(bus.sb_count), 64'd0);
        chk("async_rst_empty", 64'(bus.sb_empty), 64'd1);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("rst_keep_mem5", dut.r_mem[5], 64'h1005);
        chk("rst_keep_mem6", dut.r_mem[6], 64'h1006);
        step(0, 1, 0, 64'h28, 64'h0, rd, cnt);
        chk("rst_load", rd, 64'h1005);
`ifdef DMEM_SB_STATS_EN
        m_fwd = 0; m_forced = 0; m_stores = 0;
`endif

        // Random traffic against the model; full 64-bit addresses exercise aliasing.
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), {$urandom(), $urandom()},
                 {$urandom(), $urandom()}, rd, cnt);
        end
        for (int n = 0; n < DEPTH; n++) step(0, 0, 1, 64'h0, 64'h0, rd, cnt);
        chk("final_empty", 64'(bus.sb_empty), 64'd1);
        for (int k = 0; k < 64; k++) chk($sformatf("final_mem%0d", k), dut.r_mem[k], mem_m[k]);

`ifdef DMEM_SB_STATS_EN
        chk("stat_fwd_hits",      64'(fwd_hits),      64'(m_fwd));
        chk("stat_forced_drains", 64'(forced_drains), 64'(m_forced));
        chk("stat_stores_total",  64'(stores_total),  64'(m_stores));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
